// File: rtl/usb_personality_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : usb_personality_ctrl
// Summary  : Arbitrates CPU/host personality requests and sequences the change:
//            disconnect, mux switch, protocol reset, reconnect.
// Revision : 1.0
// ============================================================================
module usb_personality_ctrl #(
  parameter int NUM_PERSONALITIES   = 5,
  parameter int DEFAULT_PERSONALITY = 4,
  parameter int DISC_CYCLES         = 1000,
  parameter int RESET_CYCLES        = 16,
  parameter int ACK_TIMEOUT         = 1024,
  parameter int CNT_W               = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cpu_req,
  input  logic [2:0]                   cpu_sel,
  input  logic                         host_req,
  input  logic [2:0]                   host_sel,
  output logic                         cpu_done,
  output logic                         host_done,
  output logic [1:0]                   result,
  output logic [2:0]                   personality_sel,
  output logic                         personality_switch,
  input  logic                         switch_complete,
  input  logic [2:0]                   active_personality,
  output logic [NUM_PERSONALITIES-1:0] proto_rst_n,
  output logic                         usb_disconnect,
  output logic                         busy,
  output logic [7:0]                   switch_count
);

  localparam logic [2:0] C_ST_IDLE     = 3'd0;
  localparam logic [2:0] C_ST_CHECK    = 3'd1;
  localparam logic [2:0] C_ST_DISC     = 3'd2;
  localparam logic [2:0] C_ST_WAIT_ACK = 3'd3;
  localparam logic [2:0] C_ST_PRST     = 3'd4;
  localparam logic [2:0] C_ST_DONE     = 3'd5;

  localparam logic [1:0] C_RES_OK      = 2'd0;
  localparam logic [1:0] C_RES_NOOP    = 2'd1;
  localparam logic [1:0] C_RES_INVALID = 2'd2;
  localparam logic [1:0] C_RES_TIMEOUT = 2'd3;

  localparam logic [CNT_W-1:0] C_DISC_CNT = CNT_W'(DISC_CYCLES);
  localparam logic [CNT_W-1:0] C_RST_CNT  = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] C_ACK_CNT  = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       C_NUM_PERS = 4'(NUM_PERSONALITIES);
  localparam logic [2:0]       C_DEF_PERS = 3'(DEFAULT_PERSONALITY);

  logic [2:0]                   r_state;
  logic [2:0]                   w_next_state;
  logic                         r_cpu_pend;
  logic [2:0]                   r_cpu_sel;
  logic                         r_host_pend;
  logic [2:0]                   r_host_sel;
  logic [2:0]                   r_tgt;
  logic                         r_src;
  logic [CNT_W-1:0]             r_cnt;
  logic                         w_grant_cpu;
  logic                         w_grant_host;
  logic                         w_invalid;
  logic                         w_noop;
  logic                         w_cnt_last;
  logic [NUM_PERSONALITIES-1:0] w_tgt_mask;

  assign w_grant_cpu  = (r_state == C_ST_IDLE) && r_cpu_pend;
  assign w_grant_host = (r_state == C_ST_IDLE) && !r_cpu_pend && r_host_pend;
  assign w_invalid    = ({1'b0, r_tgt} >= C_NUM_PERS);
  assign w_noop       = (r_tgt == active_personality);
  assign w_cnt_last   = (r_cnt == C_CNT_ONE);

  for (genvar gi = 0; gi < NUM_PERSONALITIES; gi++) begin : g_tgt_mask
    assign w_tgt_mask[gi] = (r_tgt == 3'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_ST_IDLE: begin
        if (r_cpu_pend || r_host_pend) w_next_state = C_ST_CHECK;
      end
      C_ST_CHECK: begin
        w_next_state = (w_invalid || w_noop) ? C_ST_DONE : C_ST_DISC;
      end
      C_ST_DISC: begin
        if (w_cnt_last) w_next_state = C_ST_WAIT_ACK;
      end
      C_ST_WAIT_ACK: begin
        // A completion on the expiry cycle still wins over the timeout
        if (switch_complete)  w_next_state = C_ST_PRST;
        else if (w_cnt_last)  w_next_state = C_ST_DONE;
      end
      C_ST_PRST: begin
        if (w_cnt_last) w_next_state = C_ST_DONE;
      end
      C_ST_DONE: begin
        w_next_state = C_ST_IDLE;
      end
      default: begin
        w_next_state = C_ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (r_state != C_ST_IDLE);
    cpu_done  = (r_state == C_ST_DONE) && !r_src;
    host_done = (r_state == C_ST_DONE) && r_src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_pend         <= 1'b0;
      r_cpu_sel          <= 3'd0;
      r_host_pend        <= 1'b0;
      r_host_sel         <= 3'd0;
      r_tgt              <= 3'd0;
      r_src              <= 1'b0;
      r_cnt              <= '0;
      result             <= C_RES_OK;
      personality_sel    <= C_DEF_PERS;
      personality_switch <= 1'b0;
      proto_rst_n        <= '1;
      usb_disconnect     <= 1'b0;
      switch_count       <= 8'd0;
    end else begin
      // A fresh request outranks the grant-clear so it is never lost
      if (cpu_req) begin
        r_cpu_pend <= 1'b1;
        r_cpu_sel  <= cpu_sel;
      end else if (w_grant_cpu) begin
        r_cpu_pend <= 1'b0;
      end

      if (host_req) begin
        r_host_pend <= 1'b1;
        r_host_sel  <= host_sel;
      end else if (w_grant_host) begin
        r_host_pend <= 1'b0;
      end

      if (w_grant_cpu) begin
        r_tgt <= r_cpu_sel;
        r_src <= 1'b0;
      end else if (w_grant_host) begin
        r_tgt <= r_host_sel;
        r_src <= 1'b1;
      end

      personality_switch <= (r_state == C_ST_DISC) && w_cnt_last;

      case (r_state)
        C_ST_CHECK: begin
          if (w_invalid) begin
            result <= C_RES_INVALID;
          end else if (w_noop) begin
            result <= C_RES_NOOP;
          end else begin
            usb_disconnect <= 1'b1;
            r_cnt          <= C_DISC_CNT;
          end
        end
        C_ST_DISC: begin
          if (w_cnt_last) begin
            personality_sel <= r_tgt;
            r_cnt           <= C_ACK_CNT;
          end else begin
            r_cnt <= r_cnt - C_CNT_ONE;
          end
        end
        C_ST_WAIT_ACK: begin
          if (switch_complete) begin
            proto_rst_n <= ~w_tgt_mask;
            r_cnt       <= C_RST_CNT;
          end else if (w_cnt_last) begin
            usb_disconnect <= 1'b0;
            result         <= C_RES_TIMEOUT;
          end else begin
            r_cnt <= r_cnt - C_CNT_ONE;
          end
        end
        C_ST_PRST: begin
          if (w_cnt_last) begin
            proto_rst_n    <= '1;
            usb_disconnect <= 1'b0;
            switch_count   <= switch_count + 8'd1;
            result         <= C_RES_OK;
          end else begin
            r_cnt <= r_cnt - C_CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
